timeout_ctrl: RTL
=================

Name: timeout_ctrl

Overview:
- Supervisor and initiator for the 15 s countdown block in the vending machine.
- Tracks customer inactivity during a transaction. After GRACE_SECS seconds with no activity, it releases and enables the countdown and drives the countdown display.
- When the countdown reports overflow, it raises a cancel/refund request to the main FSM and holds it until acknowledged.
- Runs on the system clock. Seconds arrive as a one-cycle tick pulse.

Parameters:
- GRACE_SECS, 5, inactivity seconds before the countdown starts; legal range 1 .. 2^GRACE_W-1.
- GRACE_W, 3, width of the grace-second counter.

Ports:
- timeout_clk  input  1  system clock.
- timeout_reset  input  1  synchronous reset, active-high.
- timeout_tick  input  1  1 Hz strobe, one timeout_clk cycle wide.
- timeout_active  input  1  level; a transaction is in progress.
- timeout_activity  input  1  one-cycle pulse on a coin or key event.
- delay_number  input  4  current value from the countdown block.
- delay_overflow  input  1  countdown expired.
- delay_enable  output  1  countdown enable.
- delay_reset  output  1  active-low reload to the countdown; 0 holds it at 15.
- timeout_show  output  1  display the countdown digits.
- timeout_display  output  4  digit to show.
- timeout_cancel_req  output  1  cancel/refund request.
- timeout_cancel_ack  input  1  acknowledge from the main FSM, level-sampled.
- timeout_state  output  2  debug state: 0=IDLE, 1=GRACE, 2=COUNT, 3=CANCEL.

Behaviour:
- All outputs are registered. Every response appears one timeout_clk cycle after the sampled condition.
- Reset values: state IDLE, grace_cnt 0, delay_enable 0, delay_reset 0, timeout_show 0, timeout_display 0, timeout_cancel_req 0. Reset has priority over everything, including mid-handshake.
- IDLE
  - Outputs: enable 0, delay_reset 0, show 0, display 0.
  - timeout_active=1 -> GRACE with grace_cnt=0.
- GRACE
  - Outputs: enable 0, delay_reset 0, show 0.
  - Priority 1: timeout_active=0 -> IDLE.
  - Priority 2: timeout_activity -> grace_cnt=0. Activity wins over a same-cycle tick.
  - Priority 3: on tick, if grace_cnt==GRACE_SECS-1 -> COUNT and grace_cnt=0; otherwise grace_cnt+1.
  - grace_cnt never wraps.
- COUNT
  - Outputs: delay_reset 1, delay_enable 1, show 1, timeout_display=delay_number (registered copy).
  - Priority 1: timeout_active=0 -> IDLE.
  - Priority 2: delay_overflow=1 -> CANCEL. Overflow beats a same-cycle activity pulse.
  - Priority 3: timeout_activity -> GRACE with grace_cnt=0. delay_reset drops to 0, so the countdown reloads to 15.
- CANCEL
  - Outputs: delay_enable 0, delay_reset 1 (countdown frozen), show 1, timeout_display=0, timeout_cancel_req 1.
  - Activity and timeout_active are ignored; the handshake must complete.
  - timeout_cancel_ack=1 -> IDLE; req deasserts the next cycle.
  - An ack arriving while req=0 is ignored in every state.
- Entering CANCEL from COUNT asserts req exactly one cycle after overflow is sampled.
- timeout_state always mirrors the current registered state.

Optional Feature:
- Macro: TIMEOUT_WARN_EN.
- When defined:
  - Adds output timeout_warn, 1 bit, reset 0.
  - In COUNT with delay_number<=3 and delay_number!=0, timeout_warn toggles on each timeout_tick. It is 0 in every other state and is forced to 0 on leaving COUNT.
- When undefined: the port is absent; all other behaviour is identical.

Test Plan:
- Reset then active=1, 5 ticks, no activity -> state 1 after 1 cycle, state 2 one cycle after the 5th tick; delay_enable=1, delay_reset=1, show=1.
- GRACE, activity pulse coincident with the 4th tick -> grace_cnt=0; 5 further ticks are required before COUNT.
- COUNT with delay_number=7, activity pulse -> next cycle state=1, delay_reset=0, delay_enable=0, show=0.
- COUNT, delay_overflow=1 together with activity -> CANCEL. Cancel_req=1 one cycle later and stays high for 10 cycles without ack. Ack=1 -> req=0 and state=0 the next cycle.
- CANCEL, active dropped and timeout_reset pulsed for 1 cycle -> all outputs at reset values the following cycle.
- With TIMEOUT_WARN_EN: COUNT with delay_number stepping 3,2,1 on ticks -> timeout_warn toggles 0->1->0->1. Overflow -> warn=0.

Source files
------------

// File: rtl/timeout_ctrl_if.sv
// Signal bundle between the inactivity supervisor, the 15 s countdown block
// and the main FSM. The master modport is the supervisor's view; the slave
// modport is the view of everything around it.
// The timeout_warn signal exists only when TIMEOUT_WARN_EN is defined.
interface timeout_ctrl_if;
  logic       timeout_tick;
  logic       timeout_active;
  logic       timeout_activity;
  logic [3:0] delay_number;
  logic       delay_overflow;
  logic       delay_enable;
  logic       delay_reset;
  logic       timeout_show;
  logic [3:0] timeout_display;
  logic       timeout_cancel_req;
  logic       timeout_cancel_ack;
  logic [1:0] timeout_state;
`ifdef TIMEOUT_WARN_EN
  logic       timeout_warn;
`endif

  modport master (
    input  timeout_tick,
    input  timeout_active,
    input  timeout_activity,
    input  delay_number,
    input  delay_overflow,
    input  timeout_cancel_ack,
    output delay_enable,
    output delay_reset,
    output timeout_show,
    output timeout_display,
    output timeout_cancel_req,
`ifdef TIMEOUT_WARN_EN
    output timeout_warn,
`endif
    output timeout_state
  );

  modport slave (
    output timeout_tick,
    output timeout_active,
    output timeout_activity,
    output delay_number,
    output delay_overflow,
    output timeout_cancel_ack,
    input  delay_enable,
    input  delay_reset,
    input  timeout_show,
    input  timeout_display,
    input  timeout_cancel_req,
`ifdef TIMEOUT_WARN_EN
    input  timeout_warn,
`endif
    input  timeout_state
  );
endinterface

// File: rtl/timeout_ctrl.sv
// Inactivity supervisor for the vending machine's 15 s countdown.
// IDLE -> GRACE when a transaction starts; after GRACE_SECS quiet seconds the
// countdown is released (COUNT); countdown overflow raises a cancel request
// (CANCEL) that is held until the main FSM acknowledges it.
// All outputs are registered from the next state, so each response lands one
// clock after the condition that caused it.
// Optional: define TIMEOUT_WARN_EN to add the last-seconds warn toggle.
module timeout_ctrl #(
  parameter int GRACE_SECS = 5,
  parameter int GRACE_W    = 3
) (
  input  logic           timeout_clk,
  input  logic           timeout_reset,
  timeout_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRACE  = 2'd1,
    COUNT  = 2'd2,
    CANCEL = 2'd3
  } state_t;

  localparam logic [GRACE_W-1:0] GRACE_LAST = GRACE_W'(GRACE_SECS - 1);

  state_t             state_q;
  state_t             state_d;
  logic [GRACE_W-1:0] grace_q;
  logic [GRACE_W-1:0] grace_d;

  logic       enable_q;
  logic       reload_n_q;
  logic       show_q;
  logic [3:0] display_q;
  logic       cancel_req_q;

  // Next-state and grace-second counter; priorities follow the order of tests.
  always_comb begin
    state_d = state_q;
    grace_d = grace_q;
    case (state_q)
      IDLE: begin
        grace_d = '0;
        if (bus.timeout_active) state_d = GRACE;
      end
      GRACE: begin
        if (!bus.timeout_active) begin
          state_d = IDLE;
        end else if (bus.timeout_activity) begin
          grace_d = '0;
        end else if (bus.timeout_tick) begin
          if (grace_q == GRACE_LAST) begin
            state_d = COUNT;
            grace_d = '0;
          end else begin
            grace_d = grace_q + 1'b1;
          end
        end
      end
      COUNT: begin
        if (!bus.timeout_active) begin
          state_d = IDLE;
        end else if (bus.delay_overflow) begin
          state_d = CANCEL;
        end else if (bus.timeout_activity) begin
          state_d = GRACE;
          grace_d = '0;
        end
      end
      CANCEL: begin
        // Only the acknowledge can leave; activity and active are ignored.
        if (bus.timeout_cancel_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge timeout_clk) begin
    if (timeout_reset) begin
      state_q      <= IDLE;
      grace_q      <= '0;
      enable_q     <= 1'b0;
      reload_n_q   <= 1'b0;
      show_q       <= 1'b0;
      display_q    <= '0;
      cancel_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grace_q      <= grace_d;
      enable_q     <= (state_d == COUNT);
      reload_n_q   <= (state_d == COUNT) || (state_d == CANCEL);
      show_q       <= (state_d == COUNT) || (state_d == CANCEL);
      display_q    <= (state_d == COUNT) ? bus.delay_number : 4'd0;
      cancel_req_q <= (state_d == CANCEL);
    end
  end

  assign bus.delay_enable       = enable_q;
  assign bus.delay_reset        = reload_n_q;
  assign bus.timeout_show       = show_q;
  assign bus.timeout_display    = display_q;
  assign bus.timeout_cancel_req = cancel_req_q;
  assign bus.timeout_state      = state_q;

`ifdef TIMEOUT_WARN_EN
  logic warn_q;
  logic last_secs;

  assign last_secs = (bus.delay_number != 4'd0) && (bus.delay_number <= 4'd3);

  // Warn blinks once per second during the last three seconds of COUNT.
  always_ff @(posedge timeout_clk) begin
    if (timeout_reset) begin
      warn_q <= 1'b0;
    end else if (state_d != COUNT) begin
      warn_q <= 1'b0;
    end else if ((state_q == COUNT) && bus.timeout_tick && last_secs) begin
      warn_q <= ~warn_q;
    end
  end

  assign bus.timeout_warn = warn_q;
`endif

endmodule
